// File: rtl/ram_arbiter_if.sv
// Requester handshake and RAM pin bundle for ram_arbiter.
// slave = arbiter side, master = requesters plus the RAM macro.
interface ram_arbiter_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          ram_cen;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    output ack0, ack1, rdata0, rdata1, ram_cen, ram_wen, ram_addr, ram_din, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    input  ack0, ack1, rdata0, rdata1, ram_cen, ram_wen, ram_addr, ram_din, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter serialising req/ack accesses onto a single-port RAM.
// Optional macro RAM_ARB_CLEAR_EN: zero-fill the whole RAM after every reset, busy high meanwhile.
module ram_arbiter #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_arbiter_if.slave bus
);

`ifdef RAM_ARB_CLEAR_EN
  localparam int unsigned CW = AW + 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, CLEAR} state_e;
  localparam state_e RST_STATE = CLEAR;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam state_e RST_STATE = IDLE;
`endif

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          port_q, port_d;
  logic          we_q, we_d;
  logic [1:0]    ack_q, ack_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          cen_q, cen_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [DW-1:0] din_q, din_d;
  logic [1:0]    elig;
  logic          gnt1;

`ifdef RAM_ARB_CLEAR_EN
  logic          busy_q, busy_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
`endif

  // A port whose ack is high this cycle sits out one arbitration round.
  assign elig = {bus.req1 & ~ack_q[1], bus.req0 & ~ack_q[0]};
  assign gnt1 = elig[1] & (~elig[0] | ~last_q);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    port_d   = port_q;
    we_d     = we_q;
    ack_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cen_d    = 1'b0;
    wen_d    = 1'b0;
    raddr_d  = '0;
    din_d    = '0;
`ifdef RAM_ARB_CLEAR_EN
    busy_d    = 1'b0;
    clr_cnt_d = clr_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|elig) begin
          port_d  = gnt1;
          last_d  = gnt1;
          we_d    = gnt1 ? bus.we1 : bus.we0;
          cen_d   = 1'b1;
          wen_d   = we_d;
          raddr_d = gnt1 ? bus.addr1 : bus.addr0;
          din_d   = we_d ? (gnt1 ? bus.wdata1 : bus.wdata0) : '0;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        ack_d = port_q ? 2'b10 : 2'b01;
        if (!we_q) begin
          if (port_q) rdata1_d = bus.ram_dout;
          else        rdata0_d = bus.ram_dout;
        end
        state_d = IDLE;
      end
`ifdef RAM_ARB_CLEAR_EN
      CLEAR: begin
        // Counter MSB set means every address has been written.
        if (clr_cnt_q[AW]) begin
          state_d = IDLE;
        end else begin
          busy_d    = 1'b1;
          cen_d     = 1'b1;
          wen_d     = 1'b1;
          raddr_d   = clr_cnt_q[AW-1:0];
          clr_cnt_d = clr_cnt_q + CW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RST_STATE;
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      ack_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cen_q    <= 1'b0;
      wen_q    <= 1'b0;
      raddr_q  <= '0;
      din_q    <= '0;
`ifdef RAM_ARB_CLEAR_EN
      busy_q    <= 1'b0;
      clr_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      port_q   <= port_d;
      we_q     <= we_d;
      ack_q    <= ack_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cen_q    <= cen_d;
      wen_q    <= wen_d;
      raddr_q  <= raddr_d;
      din_q    <= din_d;
`ifdef RAM_ARB_CLEAR_EN
      busy_q    <= busy_d;
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  assign bus.ack0     = ack_q[0];
  assign bus.ack1     = ack_q[1];
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.ram_cen  = cen_q;
  assign bus.ram_wen  = wen_q;
  assign bus.ram_addr = raddr_q;
  assign bus.ram_din  = din_q;
`ifdef RAM_ARB_CLEAR_EN
  assign bus.busy     = busy_q;
`else
  assign bus.busy     = 1'b0;
`endif

endmodule
